riscv_enable_tag_pipe: RTL and testbench
========================================

RISCV_ENABLE_TAG_PIPE -- requirements
Module: riscv_enable_tag_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the decoded-entry FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, giving the suppression counter width.
REQ-003 SHALL have parameter LD_DECODE, default 0: 0 = loads force both enables to 1; 1 = loads decode enables from the TPR.
REQ-004 SHALL have parameters ST_A_POS, ST_B_POS, LD_A_POS, LD_B_POS, defaults 0, 1, 2, 3, giving the TPR bit index for each enable.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 instr_rdata_i  in  32  instruction word; opcode is [6:0].
REQ-008 tpr_i  in  32  Tag Propagation Register value.
REQ-009 in_valid_i  in  1  instruction and TPR valid.
REQ-010 in_ready_o  out  1  block can accept.
REQ-011 flush_i  in  1  discard all buffered entries.
REQ-012 out_valid_o  out  1  head entry valid.
REQ-013 out_ready_i  in  1  consumer takes head entry.
REQ-014 is_store_o, is_load_o, enable_a_o, enable_b_o  out  1 each  decoded head entry.
REQ-015 cnt_clr_i  in  1  clear suppression counter.
REQ-016 suppr_cnt_o  out  CNT_W  count of accepted entries with enable_a or enable_b equal to 0.

Function
REQ-017 Accept SHALL be defined as in_valid_i & in_ready_o in one cycle; pop SHALL be defined as out_valid_o & out_ready_i in one cycle.
REQ-018 Decode SHALL sample instr_rdata_i and tpr_i only in the accept cycle; later changes SHALL NOT alter stored entries.
REQ-019 Opcode 7'h23 (store) SHALL decode to is_store=1, is_load=0, enable_a=tpr[ST_A_POS], enable_b=tpr[ST_B_POS].
REQ-020 Opcode 7'h03 (load) SHALL decode to is_load=1, is_store=0; enable_a/b SHALL be 1/1 when LD_DECODE=0, and tpr[LD_A_POS]/tpr[LD_B_POS] when LD_DECODE=1.
REQ-021 Every other opcode SHALL decode to is_store=0, is_load=0, enable_a=1, enable_b=1.
REQ-022 Entries SHALL be stored in a DEPTH-entry circular FIFO (4 bits each) with log2(DEPTH)-bit read/write pointers plus an occupancy count of 0..DEPTH.
REQ-023 Latency SHALL be 1 cycle: an entry accepted in cycle N SHALL appear on the outputs with out_valid_o=1 in cycle N+1 if the FIFO was empty.
REQ-024 in_ready_o SHALL equal (count != DEPTH); no combinational path from out_ready_i to in_ready_o.
REQ-025 out_valid_o SHALL equal (count != 0); the data outputs SHALL show the head entry, and all four SHALL be 0 when empty.
REQ-026 Simultaneous accept and pop SHALL leave count unchanged, with both pointers advancing.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-028 Entries SHALL be popped strictly in accept order.
REQ-029 flush_i SHALL zero count and both pointers at the next edge, overriding any same-cycle accept or pop; an accept in a flush cycle SHALL be dropped and SHALL NOT be counted.
REQ-030 suppr_cnt_o SHALL increment by 1 on each accept whose decoded (enable_a & enable_b)==0, saturating at 2^CNT_W-1.
REQ-031 cnt_clr_i SHALL zero suppr_cnt_o, overriding a same-cycle increment.
REQ-032 suppr_cnt_o SHALL NOT be affected by flush_i.

Reset
REQ-033 While rst=1, count, pointers and suppr_cnt_o SHALL be 0, giving out_valid_o=0, in_ready_o=1 and all data outputs 0.
REQ-034 Assertion of rst mid-operation SHALL discard all entries immediately (asynchronously).
REQ-035 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-036 Store path: instr=32'h00A12023, tpr=32'h1, in_valid=1, out_ready=1 -> next cycle out_valid=1, is_store=1, enable_a=1, enable_b=0, suppr_cnt=1.
REQ-037 Load path: opcode 7'h03, tpr=32'h0 -> LD_DECODE=0 gives enable_a=1, enable_b=1, count unchanged; LD_DECODE=1 gives 0/0 and the counter increments.
REQ-038 Backpressure: DEPTH=2, out_ready=0, three back-to-back stores -> in_ready=0 after 2 accepts, third held; then out_ready=1 -> entries pop in order and the third is accepted the cycle after the first pop.
REQ-039 Flush: flush=1 and in_valid=1 in the same cycle with 2 entries held -> next cycle out_valid=0, in_ready=1, suppr_cnt unchanged.
REQ-040 Saturation: CNT_W=2, 5 suppressing accepts -> suppr_cnt=3; cnt_clr together with an accept -> 0.
REQ-041 Async reset: rst pulsed between clock edges with 1 entry held -> out_valid=0 immediately, before the next edge.

Source files
------------

// File: rtl/riscv_enable_tag_pipe.sv
// Decodes store/load enables from the Tag Propagation Register, buffers them in a
// small FIFO and counts accepted entries whose enables suppress propagation.
module riscv_enable_tag_pipe #(
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 16,
    parameter int LD_DECODE = 0,
    parameter int ST_A_POS  = 0,
    parameter int ST_B_POS  = 1,
    parameter int LD_A_POS  = 2,
    parameter int LD_B_POS  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_rdata_i,
    input  logic [31:0]      tpr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             is_store_o,
    output logic             is_load_o,
    output logic             enable_a_o,
    output logic             enable_b_o,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] suppr_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [3:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [OCC_W-1:0] r_count;
    logic [CNT_W-1:0] r_suppr_cnt;

    logic [6:0] w_opcode;
    logic       w_is_store;
    logic       w_is_load;
    logic       w_en_a;
    logic       w_en_b;
    logic [3:0] w_entry;
    logic [3:0] w_head;
    logic       w_accept;
    logic       w_pop;
    logic       w_suppress;
    logic       w_unused;

    // Handshake: a transfer happens on a side only in a cycle where both valid and
    // ready are high; ready never depends on the opposite side in the same cycle.
    assign in_ready_o  = (r_count != FULL);
    assign out_valid_o = (r_count != '0);
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;

    assign w_opcode = instr_rdata_i[6:0];
    assign w_unused = ^{instr_rdata_i[31:7], tpr_i};

    always_comb begin
        w_is_store = 1'b0;
        w_is_load  = 1'b0;
        w_en_a     = 1'b1;
        w_en_b     = 1'b1;
        if (w_opcode == 7'h23) begin
            w_is_store = 1'b1;
            w_en_a     = tpr_i[ST_A_POS];
            w_en_b     = tpr_i[ST_B_POS];
        end else if (w_opcode == 7'h03) begin
            w_is_load = 1'b1;
            if (LD_DECODE != 0) begin
                w_en_a = tpr_i[LD_A_POS];
                w_en_b = tpr_i[LD_B_POS];
            end
        end
    end

    assign w_entry    = {w_is_store, w_is_load, w_en_a, w_en_b};
    assign w_suppress = ~(w_en_a & w_en_b);

    always_ff @(posedge clk) begin
        if (w_accept && !flush_i) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A flushed accept never lands in the FIFO, so it is not counted either.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_suppr_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_suppr_cnt <= '0;
        end else if (w_accept && !flush_i && w_suppress && (r_suppr_cnt != '1)) begin
            r_suppr_cnt <= r_suppr_cnt + CNT_W'(1);
        end
    end

    assign w_head      = out_valid_o ? r_mem[r_rptr] : 4'b0000;
    assign is_store_o  = w_head[3];
    assign is_load_o   = w_head[2];
    assign enable_a_o  = w_head[1];
    assign enable_b_o  = w_head[0];
    assign suppr_cnt_o = r_suppr_cnt;

endmodule

// File: tb/tb_riscv_enable_tag_pipe.sv
// Bench for riscv_enable_tag_pipe: two configurations share one stimulus stream and
// are compared against a queue-based reference model each cycle.
module tb_riscv_enable_tag_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] tpr;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic        cnt_clr;

  logic        rdy0, vld0, st0, ld0, ea0, eb0;
  logic [15:0] cnt0;
  logic        rdy1, vld1, st1, ld1, ea1, eb1;
  logic [1:0]  cnt1;

  int n_checks = 0;
  int n_errors = 0;

  // model state, index 0 = default config, index 1 = DEPTH 4 / CNT_W 2 / LD_DECODE 1
  logic [3:0] exp_q [2][$];
  int mcnt [2];
  int mdepth [2] = '{2, 4};
  int mmax [2]   = '{65535, 3};
  int mld [2]    = '{0, 1};

  always #5 clk = ~clk;

  riscv_enable_tag_pipe u0 (
    .clk(clk), .rst(rst), .instr_rdata_i(instr), .tpr_i(tpr),
    .in_valid_i(in_valid), .in_ready_o(rdy0), .flush_i(flush),
    .out_valid_o(vld0), .out_ready_i(out_ready),
    .is_store_o(st0), .is_load_o(ld0), .enable_a_o(ea0), .enable_b_o(eb0),
    .cnt_clr_i(cnt_clr), .suppr_cnt_o(cnt0)
  );

  riscv_enable_tag_pipe #(.DEPTH(4), .CNT_W(2), .LD_DECODE(1)) u1 (
    .clk(clk), .rst(rst), .instr_rdata_i(instr), .tpr_i(tpr),
    .in_valid_i(in_valid), .in_ready_o(rdy1), .flush_i(flush),
    .out_valid_o(vld1), .out_ready_i(out_ready),
    .is_store_o(st1), .is_load_o(ld1), .enable_a_o(ea1), .enable_b_o(eb1),
    .cnt_clr_i(cnt_clr), .suppr_cnt_o(cnt1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // entry layout: {store, load, enable_a, enable_b}
  function automatic logic [3:0] decode(input logic [31:0] ins, input logic [31:0] tp, input int ld);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'h23) return {2'b10, tp[0], tp[1]};
    if (op == 7'h03) return (ld != 0) ? {2'b01, tp[2], tp[3]} : 4'b0111;
    return 4'b0011;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        exp_q[k].delete();
        mcnt[k] = 0;
      end else begin
        bit acc, pop;
        logic [3:0] e;
        e   = decode(instr, tpr, mld[k]);
        acc = in_valid && (exp_q[k].size() < mdepth[k]);
        pop = out_ready && (exp_q[k].size() > 0);
        if (flush) begin
          exp_q[k].delete();
        end else begin
          if (pop) void'(exp_q[k].pop_front());
          if (acc) exp_q[k].push_back(e);
        end
        if (cnt_clr) mcnt[k] = 0;
        else if (acc && !flush && !(e[1] && e[0]) && mcnt[k] < mmax[k]) mcnt[k]++;
      end
    end
  endtask

  task automatic compare_one(input int k, input logic v, input logic r,
                             input logic [3:0] d, input logic [31:0] c);
    logic [3:0] exp_d;
    exp_d = (exp_q[k].size() > 0) ? exp_q[k][0] : 4'b0000;
    check_eq($sformatf("u%0d_out_valid", k), {31'b0, v}, {31'b0, exp_q[k].size() > 0});
    check_eq($sformatf("u%0d_in_ready", k), {31'b0, r}, {31'b0, exp_q[k].size() < mdepth[k]});
    check_eq($sformatf("u%0d_data", k), {28'b0, d}, {28'b0, exp_d});
    check_eq($sformatf("u%0d_suppr_cnt", k), c, mcnt[k]);
  endtask

  task automatic compare();
    compare_one(0, vld0, rdy0, {st0, ld0, ea0, eb0}, {16'b0, cnt0});
    compare_one(1, vld1, rdy1, {st1, ld1, ea1, eb1}, {30'b0, cnt1});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] tp, input logic v,
                       input logic rdy, input logic fl, input logic clr);
    instr     = ins;
    tpr       = tp;
    in_valid  = v;
    out_ready = rdy;
    flush     = fl;
    cnt_clr   = clr;
  endtask

  localparam logic [31:0] STORE = 32'h00A12023;
  localparam logic [31:0] LOAD  = 32'h00012083;

  initial begin
    logic [31:0] rnd;
    logic [6:0]  op;
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle();
    rst = 1'b0;

    // store decode, latency and first suppression count
    drive(STORE, 32'h1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    check_eq("store_valid", {31'b0, vld0}, 1);
    check_eq("store_flags", {28'b0, st0, ld0, ea0, eb0}, 32'b1010);
    check_eq("store_cnt", {16'b0, cnt0}, 1);

    // load with zero TPR: forced enables vs decoded enables
    drive(LOAD, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();

    // backpressure on the shallow config, then release
    drive(STORE, 32'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle();
    check_eq("bp_full", {31'b0, rdy0}, 0);
    out_ready = 1'b1;
    repeat (2) cycle();
    in_valid = 1'b0;
    repeat (4) cycle();

    // flush with a same-cycle accept of a suppressing store
    drive(STORE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle();
    flush = 1'b1;
    cycle();
    check_eq("flush_valid", {31'b0, vld0}, 0);
    check_eq("flush_ready", {31'b0, rdy0}, 1);

    // saturation of the 2-bit counter, then clear beside an accept
    drive(STORE, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) cycle();
    check_eq("sat_cnt", {30'b0, cnt1}, 3);
    cnt_clr = 1'b1;
    cycle();
    check_eq("clr_cnt", {30'b0, cnt1}, 0);

    // asynchronous reset between edges with one entry held
    drive(STORE, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    cycle();
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", {31'b0, vld0}, 0);
    exp_q[0].delete();
    exp_q[1].delete();
    mcnt[0] = 0;
    mcnt[1] = 0;
    compare();
    #1 rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom();
      case ($urandom_range(0, 2))
        0:       op = 7'h23;
        1:       op = 7'h03;
        default: op = rnd[6:0];
      endcase
      drive({rnd[31:7], op}, $urandom(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
